// File: rtl/ram_dual_port_be.sv
// ram_dual_port_be: simple dual-port RAM, byte-enable write port A, registered read port B.
// Define RAM_DUAL_PORT_BE_INIT_CLEAR_EN to add the post-reset zero sweep.
module ram_dual_port_be #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int RDW_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_we,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_din,
    input  logic                    b_re,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    output logic [DATA_WIDTH-1:0]   b_dout,
    output logic                    b_valid,
    output logic                    init_busy
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] merged, rdata;
    logic wr, rd;
`ifdef RAM_DUAL_PORT_BE_INIT_CLEAR_EN
    localparam logic [0:0] INIT = 1'b0, READY = 1'b1;
    logic [0:0] state;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            cnt <= '0;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
            if (&cnt) state <= READY;
        end
    end
    assign init_busy = (state == INIT);
`else
    assign cnt = '0;
    assign init_busy = 1'b0;
`endif
    assign wr = a_we & ~init_busy;
    assign rd = b_re & ~init_busy;
    always_ff @(posedge clk) begin
        if (init_busy)
            mem[cnt] <= '0;
        else if (wr)
            for (int i = 0; i < NB; i++)
                if (a_be[i]) mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
    end
    // Word as it will look after this edge's write; only used for write-first collisions.
    always_comb begin
        merged = mem[a_addr];
        for (int i = 0; i < NB; i++)
            if (a_be[i]) merged[8*i +: 8] = a_din[8*i +: 8];
    end
    assign rdata = (RDW_MODE == 1 && wr && a_addr == b_addr) ? merged : mem[b_addr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_dout <= '0;
            b_valid <= 1'b0;
        end else begin
            b_valid <= rd;
            if (rd) b_dout <= rdata;
        end
    end
endmodule

// File: tb/tb_ram_dual_port_be.sv
// tb_ram_dual_port_be: directed checks of a read-first and a write-first instance driven in parallel.
module tb_ram_dual_port_be;
    logic clk = 0, rst = 1;
    logic a_we, b_re;
    logic [3:0] a_be, a_addr, b_addr;
    logic [31:0] a_din, b_dout0, b_dout1;
    logic b_valid0, b_valid1, init_busy0, init_busy1;
    int vectors = 0, miscompares = 0;
`ifdef RAM_DUAL_PORT_BE_INIT_CLEAR_EN
    localparam logic [31:0] BUSY_RST = 1;
`else
    localparam logic [31:0] BUSY_RST = 0;
`endif

    ram_dual_port_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .b_re(b_re), .b_addr(b_addr), .b_dout(b_dout0), .b_valid(b_valid0), .init_busy(init_busy0));
    ram_dual_port_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
        .b_re(b_re), .b_addr(b_addr), .b_dout(b_dout1), .b_valid(b_valid1), .init_busy(init_busy1));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        a_we = 0; a_be = 0; a_addr = 0; a_din = 0; b_re = 0; b_addr = 0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] din, input logic [3:0] be);
        a_we = 1; a_addr = addr; a_din = din; a_be = be;
        @(negedge clk);
        a_we = 0;
    endtask

    task automatic rd(input logic [3:0] addr);
        b_re = 1; b_addr = addr;
        @(negedge clk);
        b_re = 0;
    endtask

    task automatic both(input string tag, input logic [31:0] exp);
        check({tag, " dout0"}, b_dout0, exp);
        check({tag, " dout1"}, b_dout1, exp);
        check({tag, " valid"}, {30'b0, b_valid1, b_valid0}, 32'h3);
    endtask

`ifdef RAM_DUAL_PORT_BE_INIT_CLEAR_EN
    // Releases rst and counts edges until init_busy drops, with requests held active throughout.
    task automatic sweep(input string tag);
        int n = 0;
        a_we = 1; a_be = 4'hF; a_addr = 3; a_din = 32'hDEADBEEF; b_re = 1; b_addr = 3;
        rst = 0;
        do begin
            @(negedge clk);
            n++;
            check({tag, " no valid"}, {30'b0, b_valid1, b_valid0}, 0);
        end while (init_busy0 && n < 40);
        check({tag, " edges"}, 32'(n), 16);
        check({tag, " busy1"}, {31'b0, init_busy1}, 0);
        idle();
    endtask
`endif

    initial begin
        idle();
        repeat (2) @(negedge clk);
        check("rst dout", b_dout0, 0);
        check("rst valid", {31'b0, b_valid0}, 0);
        check("rst busy", {31'b0, init_busy0}, BUSY_RST);
`ifdef RAM_DUAL_PORT_BE_INIT_CLEAR_EN
        sweep("sweep");
        for (int i = 0; i < 16; i++) begin
            rd(4'(i));
            both($sformatf("clear %0d", i), 0);
        end
`else
        rst = 0;
        a_we = 1; a_addr = 15; a_din = 32'hDEADBEEF; a_be = 4'hF;
        check("busy low", {31'b0, init_busy0}, 0);
        @(negedge clk);
        a_we = 0;
        rd(15);
        both("first write", 32'hDEADBEEF);
        check("busy still low", {30'b0, init_busy1, init_busy0}, 0);
`endif
        wr(3, 32'hAABBCCDD, 4'b1111);
        wr(3, 32'h11223344, 4'b0101);
        rd(3);
        both("byte en", 32'hAA22CC44);
        wr(3, 32'h00000000, 4'b0000);
        rd(3);
        both("be zero", 32'hAA22CC44);
        @(negedge clk);
        check("hold dout", b_dout0, 32'hAA22CC44);
        check("idle valid", {30'b0, b_valid1, b_valid0}, 0);
        wr(5, 32'h12345678, 4'b1111);
        a_we = 1; a_addr = 5; a_din = 32'hFFFFFFFF; a_be = 4'b0011;
        rd(5);
        a_we = 0;
        check("rdw old", b_dout0, 32'h12345678);
        check("rdw new", b_dout1, 32'h1234FFFF);
        rd(5);
        both("after rdw", 32'h1234FFFF);
        a_we = 1; a_addr = 6; a_din = 32'h0F0F0F0F; a_be = 4'hF;
        rd(5);
        a_we = 0;
        both("diff addr", 32'h1234FFFF);
        rd(6);
        both("addr6", 32'h0F0F0F0F);
        rd(3);
        #1 rst = 1;
        #1;
        check("async valid", {30'b0, b_valid1, b_valid0}, 0);
        check("async dout", b_dout0, 0);
        check("async busy", {31'b0, init_busy0}, BUSY_RST);
        @(negedge clk);
`ifdef RAM_DUAL_PORT_BE_INIT_CLEAR_EN
        rst = 0;
        repeat (7) @(negedge clk);
        rst = 1;
        #1 check("mid busy", {31'b0, init_busy0}, 1);
        @(negedge clk);
        sweep("resweep");
        rd(3);
        both("resweep clr", 0);
`else
        rst = 0;
        @(negedge clk);
        rd(3);
        both("kept mem", 32'hAA22CC44);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ram_dual_port_be.md
# ram_dual_port_be

Simple dual-port synchronous RAM with one write port (A) and one read port (B) on a single clock.
- Port A writes with per-byte write enables.
- Port B reads with a registered output and a one-cycle valid strobe.
- A parameter selects read-during-write behaviour.
- An optional post-reset sweep clears every word to zero.

This block is the next-generation replacement for the single-port, asynchronous-read RAM in the memory subsystem. It serves buffers that need concurrent write and read and partial-word updates.

## Interface
- ADDR_WIDTH, 16, address bits; depth is 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8. NB = DATA_WIDTH/8.
- RDW_MODE, 0, same-address read-during-write policy: 0 = old data (read-first), 1 = new data (write-first).

- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- a_we  input  1  write request.
- a_be  input  NB  byte enables; bit i covers din[8i+7:8i].
- a_addr  input  ADDR_WIDTH  write address.
- a_din  input  DATA_WIDTH  write data.
- b_re  input  1  read request.
- b_addr  input  ADDR_WIDTH  read address.
- b_dout  output  DATA_WIDTH  registered read data.
- b_valid  output  1  high for one cycle when b_dout carries data for a read accepted on the previous edge.
- init_busy  output  1  high while the clear sweep runs; requests are ignored while high.

## Operation
Writes:
- A write occurs on an edge where a_we=1 and init_busy=0.
- Byte i of mem[a_addr] takes a_din byte i only where a_be[i]=1; other bytes are unchanged.
- a_we=1 with a_be all zero leaves memory unchanged.

Reads:
- A read is accepted on an edge where b_re=1 and init_busy=0.
- On that edge, b_dout loads mem[b_addr] and b_valid goes 1.
- If b_re=0, b_dout holds its previous value and b_valid goes 0.

Same-address collision (accepted write and read, a_addr==b_addr, same edge):
- RDW_MODE=0: b_dout gets the pre-write word.
- RDW_MODE=1: b_dout gets the merged word, i.e. a_din bytes where a_be=1 and old bytes elsewhere. This equals the stored result.
- Different addresses never interact.

Clear FSM (when compiled in):
- States: INIT and READY.
- rst forces INIT with sweep counter = 0.
- In INIT, each edge writes all-zero to mem[counter] and increments the counter. a_we and b_re are ignored; b_valid stays 0.
- After the edge that writes address 2**ADDR_WIDTH-1, the FSM moves to READY. The counter does not wrap back into the sweep.
- READY is held until the next rst.
- rst asserted mid-sweep or mid-operation restarts the sweep at address 0. Any read in flight is discarded (b_valid=0).

The memory array itself is never reset by rst.

## Timing
Reset values:
- b_dout = 0, b_valid = 0.
- init_busy = 1 with the clear feature, 0 without it.

Read timing:
- Read latency is 1 cycle: request at edge N, data and b_valid visible after edge N, sampled at edge N+1.
- Back-to-back reads sustain one per cycle.

Write timing:
- Write is visible to a read at a different address on the next edge.
- Write is visible to a same-address read on the same edge only in RDW_MODE=1.

Clear sweep timing:
- The sweep takes exactly 2**ADDR_WIDTH edges after rst deasserts.
- init_busy falls after the final sweep edge.
- The first request that can be accepted is on the edge following that.

## Configuration
- RAM_DUAL_PORT_BE_INIT_CLEAR_EN defined:
  - The clear FSM and sweep counter are present.
  - Memory reads as zero everywhere after the sweep.
- Not defined:
  - The FSM and counter are absent and init_busy is tied to 0.
  - Requests are accepted on the first edge after rst deasserts.
  - Unwritten contents are undefined (X in simulation).
  - rst affects only b_dout and b_valid.

## Test plan
All scenarios use ADDR_WIDTH=4, DATA_WIDTH=32, macro defined unless stated.

1. Sweep:
   - Stimulus: release rst, then count edges.
   - Response: init_busy=1 for exactly 16 edges then 0. Reads of addresses 0..15 return 0x00000000 with b_valid=1 one cycle after each b_re.
2. Byte enables:
   - Stimulus: write 0xAABBCCDD with be=4'b1111 to addr 3, then 0x11223344 with be=4'b0101.
   - Response: read addr 3 returns 0xAA22CC44. A further write with be=4'b0000 leaves it unchanged.
3. Collision, RDW_MODE=0:
   - Stimulus: addr 5 holds 0x12345678; on the same edge, write 0xFFFFFFFF with be=4'b0011 and read addr 5.
   - Response: b_dout=0x12345678; a read on the next cycle gives 0x1234FFFF.
4. Collision, RDW_MODE=1:
   - Stimulus: same as scenario 3.
   - Response: b_dout=0x1234FFFF on the colliding read.
5. Reset mid-sweep:
   - Stimulus: assert rst at sweep count 7 with a read pending.
   - Response: b_valid=0 and b_dout=0 immediately. The sweep restarts and init_busy stays high 16 edges after release. Requests issued during the sweep cause no write and no b_valid.
6. Macro undefined:
   - Stimulus: release rst; write 0xDEADBEEF to addr 15 on the first edge; read addr 15 on the next edge.
   - Response: init_busy=0 throughout; b_dout=0xDEADBEEF with b_valid=1.
